sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//   Expands one padded 512-bit SHA-256 block into the 64-word message schedule W[0..63].
//   Emits one 32-bit word per cycle to the compression-round datapath.
//   Sits between the message padder (which produces the 512-bit block from MSG_SIZE
//   message bits) and the round engine inside top.
//   Uses a 16-word rolling window, not a 64-word array.
// PARAMETERS
//   BLOCK_SIZE  512  padded block width in bits; must equal 16*WORD
//   WORD        32   schedule word width in bits
//   ROUNDS      64   number of W words emitted per block
// PORTS
//   clk      in   1    system clock, rising-edge active
//   reset    in   1    asynchronous, active-low reset (0 = reset)
//   start    in   1    request to load block; accepted only when ready=1
//   block    in   512  padded block; block[511:480] is W0, block[31:0] is W15
//   hold     in   1    consumer stall; while 1 in RUN, schedule freezes
//   ready    out  1    1 when IDLE and able to accept start
//   w_valid  out  1    1 while w_t/t_idx carry a valid schedule word
//   w_t      out  32   current schedule word W[t_idx]
//   t_idx    out  6    index of w_t, 0..63
//   done     out  1    one-cycle pulse after W63 is consumed
// BEHAVIOUR
//   Reset (reset=0, async) forces:
//     - state=IDLE; window and counter cleared
//     - ready=1, w_valid=0, w_t=0, t_idx=0, done=0
//   Reset mid-RUN aborts the block; no done pulse.
//   States: IDLE, RUN, FIN.
//   IDLE:
//     - ready=1; start=1 loads win[0..15] <= block words (win[0]=W0); cnt <= 0; go RUN.
//     - start=0: stay IDLE.
//   RUN:
//     - ready=0, w_valid=1, w_t=win[0], t_idx=cnt.
//     - A word is consumed on any RUN cycle with hold=0.
//     - On consume:
//         win[i] <= win[i+1] for i=0..14
//         win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32
//         cnt <= cnt+1
//     - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//     - hold=1: win, cnt, w_t and t_idx hold their values; w_valid stays 1.
//     - Consume with cnt=63: go FIN.
//   FIN:
//     - w_valid=0, done=1 for exactly one cycle, ready=0; next state IDLE.
//   Latency: first word (W0) appears the cycle after the start-accept edge.
//     With hold=0 throughout, W63 is on the outputs 64 cycles after accept;
//     done is high 65 cycles after accept.
//   start while not IDLE is ignored; block is sampled only on the accept edge.
//   hold is ignored outside RUN. cnt saturates at 63 and never wraps within a block.
//   start at the FIN edge is ignored. Back-to-back blocks: start may be accepted in
//     the cycle after done.
//   All adds truncate to WORD bits; no carry-out is kept.
// TESTING
//   1. Reset: reset=0 at any time -> ready=1, w_valid=0, done=0, t_idx=0 next sample.
//   2. "abc" block 0x61626380_0..0_00000018, hold=0 -> W0=61626380, W1..14=0,
//      W15=00000018, W16=61626380, W17=000F0000. All 64 words must match the
//      C reference model. done pulses at accept+65.
//   3. All-zero block -> w_t=0 for t=0..63. w_valid high for 64 consecutive
//      cycles, then done for 1 cycle.
//   4. "Hello, SHA-256!" padded block with hold=1 for 3 cycles at t_idx=16 ->
//      w_t/t_idx frozen 3 cycles. Sequence still matches the model; done at accept+68.
//   5. start pulsed at t_idx=30 with a different block -> ignored; W stream
//      unchanged; ready=0 until after done.
//   6. reset=0 asserted at t_idx=40, then released; start a new block ->
//      restarts at W0 of the new block; no done for the aborted block.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// Handshake and data bundle between the block source, the message schedule and the round engine.
interface sha256_msg_schedule_if #(
    parameter int unsigned BLOCK_SIZE = 512,
    parameter int unsigned WORD       = 32,
    parameter int unsigned IDX_W      = 6
);
    logic                  start;
    logic [BLOCK_SIZE-1:0] block;
    logic                  hold;
    logic                  ready;
    logic                  w_valid;
    logic [WORD-1:0]       w_t;
    logic [IDX_W-1:0]      t_idx;
    logic                  done;

    // Producer / consumer side: drives the block request and the stall.
    modport master (
        output start, block, hold,
        input  ready, w_valid, w_t, t_idx, done
    );

    // Schedule side.
    modport slave (
        input  start, block, hold,
        output ready, w_valid, w_t, t_idx, done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63], one word per cycle,
// using a 16-word rolling window.
module sha256_msg_schedule #(
    parameter int unsigned BLOCK_SIZE = 512,
    parameter int unsigned WORD       = 32,
    parameter int unsigned ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sha256_msg_schedule_if.slave  bus
);

    localparam int unsigned N_WIN = 16;
    localparam int unsigned IDX_W = $clog2(ROUNDS);
    localparam int unsigned LAST  = ROUNDS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD-1:0]    r_win [N_WIN];
    logic [IDX_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_w_valid;
    logic               r_done;
    logic               w_consume;
    logic               w_last;
    logic               w_accept;
    logic [WORD-1:0]    w_new;

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int unsigned n);
        rotr = (x >> n) | (x << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] sig0(input logic [WORD-1:0] x);
        sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD-1:0] sig1(input logic [WORD-1:0] x);
        sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_consume = (r_state == RUN) && !bus.hold;
    assign w_last    = (r_cnt == IDX_W'(LAST));
    // Next schedule word; all adds wrap at WORD bits.
    assign w_new     = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_consume && w_last) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered status flags derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_w_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt == IDLE);
            r_w_valid <= (w_state_nxt == RUN);
            r_done    <= (w_state_nxt == FIN);
        end
    end

    // Window load on accept, shift-and-extend on each consumed word; counter saturates at the last round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_WIN; i++) r_win[i] <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            for (int unsigned i = 0; i < N_WIN; i++) begin
                r_win[i] <= bus.block[BLOCK_SIZE-1-i*WORD -: WORD];
            end
            r_cnt <= '0;
        end else if (w_consume) begin
            for (int unsigned i = 0; i < N_WIN - 1; i++) r_win[i] <= r_win[i+1];
            r_win[N_WIN-1] <= w_new;
            if (!w_last) r_cnt <= r_cnt + IDX_W'(1);
        end
    end

    assign bus.ready   = r_ready;
    assign bus.w_valid = r_w_valid;
    assign bus.done    = r_done;
    assign bus.w_t     = r_win[0];
    assign bus.t_idx   = r_cnt;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule; expected words come from a 64-entry array model.
module tb_sha256_msg_schedule;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] HELLO_BLK = {32'h48656c6c, 32'h6f2c2053, 32'h48412d32,
                                          32'h35362180, 352'h0, 32'h00000078};
    localparam logic [511:0] ZERO_BLK  = 512'h0;
    localparam logic [511:0] ALT_BLK   = {16{32'hdeadbeef}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_w [0:63];
    logic [31:0] cap_w [0:99];
    logic [5:0]  cap_t [0:99];
    logic        cap_v [0:99];
    logic        cap_d [0:99];
    logic        cap_r [0:99];

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    // Reference schedule built as a full 64-entry array.
    task automatic build_model(input logic [511:0] b);
        logic [31:0] w [0:63];
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = m_rotr(w[i-15], 7) ^ m_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = m_rotr(w[i-2], 17) ^ m_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) exp_w[i] = w[i];
    endtask

    function automatic int exp_idx(input int n, input int hold_t, input int hold_n);
        if (hold_n == 0 || n <= hold_t + 1) return n - 1;
        if (n <= hold_t + 1 + hold_n) return hold_t;
        return n - 1 - hold_n;
    endfunction

    // Accept block b, then sample ncyc cycles on the falling edge; optionally stall or re-pulse start.
    task automatic run_block(input logic [511:0] b, input int ncyc, input int hold_t,
                             input int hold_n, input int start_t, input logic [511:0] alt);
        int held     = 0;
        bit injected = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.block = b;
        bus.hold  = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            cap_w[n] = bus.w_t;
            cap_t[n] = bus.t_idx;
            cap_v[n] = bus.w_valid;
            cap_d[n] = bus.done;
            cap_r[n] = bus.ready;
            bus.hold = 1'b0;
            if (hold_n > 0 && bus.w_valid && int'(bus.t_idx) == hold_t && held < hold_n) begin
                bus.hold = 1'b1;
                held++;
            end
            if (start_t >= 0 && bus.w_valid && int'(bus.t_idx) == start_t && !injected) begin
                bus.start = 1'b1;
                bus.block = alt;
                injected  = 1;
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.block = '0;
        #12;
        tests_run++;
        if (bus.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b expected 1", bus.ready); end
        tests_run++;
        if (bus.w_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b expected 0", bus.w_valid); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b expected 0", bus.done); end
        tests_run++;
        if (bus.t_idx !== 6'd0) begin tests_failed++; $display("FAIL reset_tidx got %0d expected 0", bus.t_idx); end
        tests_run++;
        if (bus.w_t !== 32'h0) begin tests_failed++; $display("FAIL reset_wt got %h expected 0", bus.w_t); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset ready=%b valid=%b expected 1/0", bus.ready, bus.w_valid);
        end
    endtask

    task automatic test_abc();
        build_model(ABC_BLK);
        run_block(ABC_BLK, 66, 0, 0, -1, ZERO_BLK);
        tests_run++;
        if (cap_w[1] !== 32'h61626380) begin tests_failed++; $display("FAIL abc_w0 got %h expected 61626380", cap_w[1]); end
        tests_run++;
        if (cap_w[16] !== 32'h00000018) begin tests_failed++; $display("FAIL abc_w15 got %h expected 00000018", cap_w[16]); end
        tests_run++;
        if (cap_w[17] !== 32'h61626380) begin tests_failed++; $display("FAIL abc_w16 got %h expected 61626380", cap_w[17]); end
        tests_run++;
        if (cap_w[18] !== 32'h000f0000) begin tests_failed++; $display("FAIL abc_w17 got %h expected 000f0000", cap_w[18]); end
        for (int n = 1; n <= 64; n++) begin
            tests_run++;
            if (cap_v[n] !== 1'b1 || cap_d[n] !== 1'b0 || cap_r[n] !== 1'b0) begin
                tests_failed++;
                $display("FAIL abc_flags n=%0d valid=%b done=%b ready=%b expected 1/0/0", n, cap_v[n], cap_d[n], cap_r[n]);
            end
            tests_run++;
            if (cap_t[n] !== 6'(n - 1) || cap_w[n] !== exp_w[n-1]) begin
                tests_failed++;
                $display("FAIL abc_word n=%0d got t=%0d w=%h expected t=%0d w=%h", n, cap_t[n], cap_w[n], n - 1, exp_w[n-1]);
            end
        end
        tests_run++;
        if (cap_d[65] !== 1'b1 || cap_v[65] !== 1'b0 || cap_r[65] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abc_done done=%b valid=%b ready=%b expected 1/0/0", cap_d[65], cap_v[65], cap_r[65]);
        end
        tests_run++;
        if (cap_d[66] !== 1'b0 || cap_r[66] !== 1'b1) begin
            tests_failed++;
            $display("FAIL abc_idle done=%b ready=%b expected 0/1", cap_d[66], cap_r[66]);
        end
    endtask

    task automatic test_zero();
        run_block(ZERO_BLK, 66, 0, 0, -1, ZERO_BLK);
        for (int n = 1; n <= 64; n++) begin
            tests_run++;
            if (cap_v[n] !== 1'b1 || cap_w[n] !== 32'h0 || cap_t[n] !== 6'(n - 1)) begin
                tests_failed++;
                $display("FAIL zero_word n=%0d valid=%b w=%h t=%0d expected 1/0/%0d", n, cap_v[n], cap_w[n], cap_t[n], n - 1);
            end
        end
        tests_run++;
        if (cap_d[65] !== 1'b1 || cap_v[65] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_done done=%b valid=%b expected 1/0", cap_d[65], cap_v[65]);
        end
        tests_run++;
        if (cap_d[66] !== 1'b0) begin tests_failed++; $display("FAIL zero_done_pulse got %b expected 0", cap_d[66]); end
    endtask

    task automatic test_hold();
        int e;
        build_model(HELLO_BLK);
        run_block(HELLO_BLK, 69, 16, 3, -1, ZERO_BLK);
        for (int n = 1; n <= 67; n++) begin
            e = exp_idx(n, 16, 3);
            tests_run++;
            if (cap_v[n] !== 1'b1 || cap_d[n] !== 1'b0 || cap_t[n] !== 6'(e) || cap_w[n] !== exp_w[e]) begin
                tests_failed++;
                $display("FAIL hold_word n=%0d valid=%b done=%b t=%0d w=%h expected 1/0/%0d/%h",
                         n, cap_v[n], cap_d[n], cap_t[n], cap_w[n], e, exp_w[e]);
            end
        end
        tests_run++;
        if (cap_d[68] !== 1'b1 || cap_v[68] !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_done done=%b valid=%b expected 1/0", cap_d[68], cap_v[68]);
        end
        tests_run++;
        if (cap_d[69] !== 1'b0 || cap_r[69] !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_idle done=%b ready=%b expected 0/1", cap_d[69], cap_r[69]);
        end
    endtask

    task automatic test_start_ignored();
        build_model(ABC_BLK);
        run_block(ABC_BLK, 66, 0, 0, 30, ALT_BLK);
        for (int n = 1; n <= 64; n++) begin
            tests_run++;
            if (cap_r[n] !== 1'b0 || cap_t[n] !== 6'(n - 1) || cap_w[n] !== exp_w[n-1]) begin
                tests_failed++;
                $display("FAIL ign_word n=%0d ready=%b t=%0d w=%h expected 0/%0d/%h", n, cap_r[n], cap_t[n], cap_w[n], n - 1, exp_w[n-1]);
            end
        end
        tests_run++;
        if (cap_d[65] !== 1'b1 || cap_r[65] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ign_done done=%b ready=%b expected 1/0", cap_d[65], cap_r[65]);
        end
        tests_run++;
        if (cap_r[66] !== 1'b1 || cap_v[66] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ign_idle ready=%b valid=%b expected 1/0", cap_r[66], cap_v[66]);
        end
    endtask

    task automatic test_reset_abort();
        bit reached = 0;
        int dones   = 0;
        int not_rdy = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.block = ABC_BLK;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            if (bus.w_valid && bus.t_idx == 6'd40) reached = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!reached) begin tests_failed++; $display("FAIL abort_reach t_idx=%0d expected 40", bus.t_idx); end
        reset = 1'b0;
        #2;
        tests_run++;
        if (bus.ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.done !== 1'b0 || bus.t_idx !== 6'd0) begin
            tests_failed++;
            $display("FAIL abort_reset ready=%b valid=%b done=%b t=%0d expected 1/0/0/0", bus.ready, bus.w_valid, bus.done, bus.t_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) dones++;
            if (bus.ready !== 1'b1) not_rdy++;
        end
        tests_run++;
        if (dones != 0 || not_rdy != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done done_cycles=%0d not_ready_cycles=%0d expected 0/0", dones, not_rdy);
        end
        build_model(HELLO_BLK);
        run_block(HELLO_BLK, 65, 0, 0, -1, ZERO_BLK);
        for (int n = 1; n <= 64; n++) begin
            tests_run++;
            if (cap_t[n] !== 6'(n - 1) || cap_w[n] !== exp_w[n-1]) begin
                tests_failed++;
                $display("FAIL abort_new n=%0d t=%0d w=%h expected %0d/%h", n, cap_t[n], cap_w[n], n - 1, exp_w[n-1]);
            end
        end
        tests_run++;
        if (cap_w[1] !== 32'h48656c6c) begin tests_failed++; $display("FAIL abort_new_w0 got %h expected 48656c6c", cap_w[1]); end
        tests_run++;
        if (cap_d[65] !== 1'b1) begin tests_failed++; $display("FAIL abort_new_done got %b expected 1", cap_d[65]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.block = ZERO_BLK;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (bus.done) seen = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL b2b_first_done got 0 expected 1"); end
        // start raised during the done cycle: the FIN edge must ignore it, the next edge accepts.
        bus.start = 1'b1;
        bus.block = ABC_BLK;
        @(negedge clk);
        tests_run++;
        if (bus.ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_fin_ignore ready=%b valid=%b done=%b expected 1/0/0", bus.ready, bus.w_valid, bus.done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.w_valid !== 1'b1 || bus.t_idx !== 6'd0 || bus.w_t !== 32'h61626380) begin
            tests_failed++;
            $display("FAIL b2b_second_w0 valid=%b t=%0d w=%h expected 1/0/61626380", bus.w_valid, bus.t_idx, bus.w_t);
        end
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL b2b_second_done got 0 expected 1"); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_zero();
        test_hold();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
